// File: rtl/pipe_sequencer.sv
// Five-state pipeline sequencer: drives the fetch PC and per-stage enables of a
// four-stage in-order pipeline. It freezes on memory back-pressure and inserts a
// bubble on load-use hazards. On a control transfer it squashes fetch and waits
// for resolution. It drains the pipeline on halt and keeps saturating counters.
module pipe_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             mem_busy,
  input  logic             dec_may_jump,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_jump_valid,
  input  logic             ex_jump_taken,
  input  logic [31:0]      ex_jump_dest,
  output logic [31:0]      pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             write_en,
  output logic             decode_hold,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_spurious
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StBrWait = 3'd2,
    StDrain  = 3'd3,
    StHalted = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      PcStep = 32'(PC_STEP);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             fe_q, fe_d;
  logic             de_q, de_d;
  logic             ee_q, ee_d;
  logic             we_q, we_d;
  logic             hold_q, hold_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;

  logic             load_use;
  logic             branch;
  logic             any_en;
  logic [CNT_W-1:0] stall_inc;
  logic [CNT_W-1:0] flush_inc;

  // Hazard detection and saturating increments.
  assign load_use = de_q && ee_q && ex_is_load && (ex_rd != 5'd0) &&
                    ((dec_use_rs1 && (dec_rs1 == ex_rd)) ||
                     (dec_use_rs2 && (dec_rs2 == ex_rd)));
  assign branch   = (state_q == StRun) && de_q && dec_may_jump && !load_use;
  assign any_en   = fe_q | de_q | ee_q | we_q;

  assign stall_inc = (stall_q == CntMax) ? stall_q : stall_q + CntOne;
  assign flush_inc = (flush_q == CntMax) ? flush_q : flush_q + CntOne;

  // State register plus all registered outputs; synchronous reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      fe_q    <= 1'b0;
      de_q    <= 1'b0;
      ee_q    <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fe_q    <= fe_d;
      de_q    <= de_d;
      ee_q    <= ee_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state: freeze and load-use bubbles keep the current state.
  always_comb begin
    state_d = state_q;
    if (!mem_busy && !load_use) begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StRun;
        end
        StRun: begin
          if (branch)    state_d = StBrWait;
          else if (halt) state_d = StDrain;
        end
        StBrWait: begin
          if (ex_jump_valid) state_d = (pend_q || halt) ? StDrain : StRun;
        end
        StDrain: begin
          if (!any_en) state_d = StHalted;
        end
        StHalted: state_d = StHalted;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Datapath next values: PC, stage enables, hold, counters and flags.
  always_comb begin
    pc_d    = pc_q;
    fe_d    = fe_q;
    de_d    = de_q;
    ee_d    = ee_q;
    we_d    = we_q;
    hold_d  = 1'b0;
    stall_d = stall_q;
    flush_d = flush_q;
    pend_d  = pend_q;
    // A resolution report is only meaningful while waiting on a branch.
    err_d   = err_q | (ex_jump_valid && (state_q != StBrWait));

    if (mem_busy) begin
      hold_d  = 1'b1;
      stall_d = stall_inc;
    end else if (load_use) begin
      // Decode keeps its instruction; a bubble enters execute.
      hold_d  = 1'b1;
      ee_d    = 1'b0;
      we_d    = ee_q;
      stall_d = stall_inc;
    end else begin
      unique case (state_q)
        StIdle: begin
          fe_d = start;
          de_d = 1'b0;
          ee_d = 1'b0;
          we_d = 1'b0;
        end
        StRun: begin
          if (branch) begin
            // The instruction behind the jump is squashed; the jump moves on.
            fe_d    = 1'b0;
            de_d    = 1'b0;
            ee_d    = 1'b1;
            we_d    = ee_q;
            flush_d = flush_inc;
          end else if (halt) begin
            fe_d = 1'b0;
            de_d = fe_q;
            ee_d = de_q;
            we_d = ee_q;
          end else begin
            fe_d = 1'b1;
            de_d = fe_q;
            ee_d = de_q;
            we_d = ee_q;
            pc_d = pc_q + PcStep;
          end
        end
        StBrWait: begin
          fe_d = 1'b0;
          de_d = 1'b0;
          ee_d = de_q;
          we_d = ee_q;
          if (ex_jump_valid) begin
            // Not taken: the held PC re-fetches the fall-through instruction.
            pc_d   = ex_jump_taken ? ex_jump_dest : pc_q;
            fe_d   = !(pend_q || halt);
            pend_d = 1'b0;
          end else begin
            stall_d = stall_inc;
            if (halt) pend_d = 1'b1;
          end
        end
        StDrain: begin
          fe_d = 1'b0;
          de_d = fe_q;
          ee_d = de_q;
          we_d = ee_q;
        end
        StHalted: begin
          fe_d = 1'b0;
          de_d = 1'b0;
          ee_d = 1'b0;
          we_d = 1'b0;
        end
        default: begin
          fe_d = 1'b0;
          de_d = 1'b0;
          ee_d = 1'b0;
          we_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  assign pc           = pc_q;
  assign fetch_en     = fe_q;
  assign decode_en    = de_q;
  assign execute_en   = ee_q;
  assign write_en     = we_q;
  assign decode_hold  = hold_q;
  assign state        = state_q;
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flush_q;
  assign err_spurious = err_q;

endmodule
